// File: rtl/ula_controle_seq_pkg.sv
// ula_ctrl_pkg: ALU select codes, AluOP classes, funct codes and sequencer states
// shared by the ALU-control sequencer, its decoder and its bus interface.
package ula_ctrl_pkg;

  // ALU select codes driven on sinal_controle
  localparam logic [3:0] ULA_AND = 4'd0;
  localparam logic [3:0] ULA_OR  = 4'd1;
  localparam logic [3:0] ULA_ADD = 4'd2;
  localparam logic [3:0] ULA_SUB = 4'd3;
  localparam logic [3:0] ULA_MUL = 4'd4;
  localparam logic [3:0] ULA_DIV = 4'd5;
  localparam logic [3:0] ULA_SRL = 4'd6;
  localparam logic [3:0] ULA_SLL = 4'd7;
  localparam logic [3:0] ULA_NOR = 4'd8;
  localparam logic [3:0] ULA_BEQ = 4'd9;
  localparam logic [3:0] ULA_BNE = 4'd10;
  localparam logic [3:0] ULA_SLT = 4'd11;
  localparam logic [3:0] ULA_LUI = 4'd12;
  localparam logic [3:0] ULA_BGT = 4'd13;
  localparam logic [3:0] ULA_BLE = 4'd14;
  localparam logic [3:0] ULA_NOP = 4'd15;

  // AluOP classes from the main control unit
  localparam logic [3:0] OP_LWSW  = 4'd0;
  localparam logic [3:0] OP_RTYPE = 4'd1;
  localparam logic [3:0] OP_BEQ   = 4'd2;
  localparam logic [3:0] OP_BNE   = 4'd3;
  localparam logic [3:0] OP_SLTI  = 4'd4;
  localparam logic [3:0] OP_LUI   = 4'd5;
  localparam logic [3:0] OP_ANDI  = 4'd6;
  localparam logic [3:0] OP_ORI   = 4'd7;
  localparam logic [3:0] OP_ADDI  = 4'd8;
  localparam logic [3:0] OP_SUBI  = 4'd9;
  localparam logic [3:0] OP_BGT   = 4'd10;
  localparam logic [3:0] OP_BLE   = 4'd11;

  // R-type funct codes; 0..8 map straight onto the select code
  localparam logic [3:0] FN_AND = 4'd0;
  localparam logic [3:0] FN_OR  = 4'd1;
  localparam logic [3:0] FN_ADD = 4'd2;
  localparam logic [3:0] FN_SUB = 4'd3;
  localparam logic [3:0] FN_MUL = 4'd4;
  localparam logic [3:0] FN_DIV = 4'd5;
  localparam logic [3:0] FN_SRL = 4'd6;
  localparam logic [3:0] FN_SLL = 4'd7;
  localparam logic [3:0] FN_NOR = 4'd8;
  localparam logic [3:0] FN_JR  = 4'd9;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SINGLE = 2'd1,
    ST_MULTI  = 2'd2
  } state_e;

endpackage

// File: rtl/ula_controle_seq_if.sv
// Issue/select bus between ID/EX control (master) and the ALU-control sequencer (slave).
interface ula_controle_seq_if #(
  parameter int unsigned OP_W    = 4,
  parameter int unsigned FUNCT_W = 4,
  parameter int unsigned CTRL_W  = 4
);
  logic               issue_valid;
  logic [OP_W-1:0]    AluOP;
  logic [FUNCT_W-1:0] funct;
  logic               flush;
  logic               issue_ready;
  logic [CTRL_W-1:0]  sinal_controle;
  logic               ctrl_valid;
  logic               stall;
  logic               op_done;
  logic               illegal;

  modport master (
    output issue_valid, AluOP, funct, flush,
    input  issue_ready, sinal_controle, ctrl_valid, stall, op_done, illegal
  );

  modport slave (
    input  issue_valid, AluOP, funct, flush,
    output issue_ready, sinal_controle, ctrl_valid, stall, op_done, illegal
  );
endinterface

// File: rtl/ula_controle_seq_decode.sv
// ula_ctrl_decode: pure combinational AluOP/funct -> ALU select table.
// undef flags a select that fell through to the default NOP (jr is an explicit NOP).
module ula_ctrl_decode
  import ula_ctrl_pkg::*;
#(
  parameter int unsigned OP_W    = 4,
  parameter int unsigned FUNCT_W = 4,
  parameter int unsigned CTRL_W  = 4
) (
  input  logic [OP_W-1:0]    alu_op,
  input  logic [FUNCT_W-1:0] funct,
  output logic [CTRL_W-1:0]  sel,
  output logic               undef
);
  localparam int unsigned OPX = (OP_W > 4) ? OP_W : 4;
  localparam int unsigned FNX = (FUNCT_W > 4) ? FUNCT_W : 4;

  logic [OPX-1:0] op_x;
  logic [FNX-1:0] fn_x;
  logic [3:0]     sel4;

  // Table lookup; wide encodings compare as a whole so set upper bits decode to NOP
  always_comb begin
    op_x  = OPX'(alu_op);
    fn_x  = FNX'(funct);
    sel4  = ULA_NOP;
    undef = 1'b1;
    case (op_x)
      OPX'(OP_LWSW): begin sel4 = ULA_ADD; undef = 1'b0; end
      OPX'(OP_BEQ):  begin sel4 = ULA_BEQ; undef = 1'b0; end
      OPX'(OP_BNE):  begin sel4 = ULA_BNE; undef = 1'b0; end
      OPX'(OP_SLTI): begin sel4 = ULA_SLT; undef = 1'b0; end
      OPX'(OP_LUI):  begin sel4 = ULA_LUI; undef = 1'b0; end
      OPX'(OP_ANDI): begin sel4 = ULA_AND; undef = 1'b0; end
      OPX'(OP_ORI):  begin sel4 = ULA_OR;  undef = 1'b0; end
      OPX'(OP_ADDI): begin sel4 = ULA_ADD; undef = 1'b0; end
      OPX'(OP_SUBI): begin sel4 = ULA_SUB; undef = 1'b0; end
      OPX'(OP_BGT):  begin sel4 = ULA_BGT; undef = 1'b0; end
      OPX'(OP_BLE):  begin sel4 = ULA_BLE; undef = 1'b0; end
      OPX'(OP_RTYPE): begin
        if (fn_x <= FNX'(FN_NOR)) begin
          sel4  = fn_x[3:0];
          undef = 1'b0;
        end else if (fn_x == FNX'(FN_JR)) begin
          undef = 1'b0;
        end
      end
      default: ;
    endcase
    sel = CTRL_W'(sel4);
  end
endmodule

// File: rtl/ula_controle_seq.sv
// ula_controle_seq: registered ALU-control sequencer. Decodes AluOP/funct, holds
// the select for the full latency of mul/div, and drives stall/op_done upstream.
// Optional sticky illegal-op flag: define ULA_CTRL_ILLEGAL_TRAP_EN.
module ula_controle_seq
  import ula_ctrl_pkg::*;
#(
  parameter int unsigned OP_W    = 4,
  parameter int unsigned FUNCT_W = 4,
  parameter int unsigned CTRL_W  = 4,
  parameter int unsigned MUL_LAT = 4,
  parameter int unsigned DIV_LAT = 8
) (
  input  logic             clock,
  input  logic             reset_n,
  ula_controle_seq_if.slave bus
);
  localparam int unsigned MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int unsigned LAT_CAP = (MAX_LAT < 1) ? 1 : MAX_LAT;
  localparam int unsigned CNT_W   = $clog2(LAT_CAP + 1);
  localparam logic [CTRL_W-1:0] SEL_NOP = CTRL_W'(ULA_NOP);
  localparam logic [CTRL_W-1:0] SEL_MUL = CTRL_W'(ULA_MUL);
  localparam logic [CTRL_W-1:0] SEL_DIV = CTRL_W'(ULA_DIV);
  localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CTRL_W-1:0] sel_q, sel_d;
  logic              valid_q, valid_d;
  logic              stall_q, stall_d;
  logic              done_q, done_d;

  logic [CTRL_W-1:0] dec_sel;
  logic              dec_undef;
  logic              ready_c;
  logic              accept_c;

  ula_ctrl_decode #(
    .OP_W   (OP_W),
    .FUNCT_W(FUNCT_W),
    .CTRL_W (CTRL_W)
  ) u_dec (
    .alu_op(bus.AluOP),
    .funct (bus.funct),
    .sel   (dec_sel),
    .undef (dec_undef)
  );

  // Ready whenever the live op ends this cycle (or nothing is live)
  assign ready_c  = (state_q != ST_MULTI) || (cnt_q == CNT_ONE);
  assign accept_c = bus.issue_valid & ready_c & ~bus.flush;

  // Next-state: flush beats issue; mul/div with latency >1 enter MULTI
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sel_d   = sel_q;
    if (bus.flush) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      sel_d   = SEL_NOP;
    end else if (accept_c) begin
      sel_d = dec_sel;
      if ((dec_sel == SEL_MUL) && (MUL_LAT > 1)) begin
        state_d = ST_MULTI;
        cnt_d   = CNT_W'(MUL_LAT);
      end else if ((dec_sel == SEL_DIV) && (DIV_LAT > 1)) begin
        state_d = ST_MULTI;
        cnt_d   = CNT_W'(DIV_LAT);
      end else begin
        state_d = ST_SINGLE;
        cnt_d   = '0;
      end
    end else begin
      case (state_q)
        ST_SINGLE: begin
          state_d = ST_IDLE;
          sel_d   = SEL_NOP;
        end
        ST_MULTI: begin
          if (cnt_q > CNT_ONE) begin
            cnt_d = cnt_q - CNT_ONE;
          end else begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            sel_d   = SEL_NOP;
          end
        end
        default: ;
      endcase
    end
    valid_d = (state_d != ST_IDLE);
    stall_d = (state_d == ST_MULTI) && (cnt_d > CNT_ONE);
    done_d  = (state_d == ST_SINGLE) || ((state_d == ST_MULTI) && (cnt_d == CNT_ONE));
  end

  // Sequencer state and registered pipeline-control outputs
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      sel_q   <= SEL_NOP;
      valid_q <= 1'b0;
      stall_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      valid_q <= valid_d;
      stall_q <= stall_d;
      done_q  <= done_d;
    end
  end

`ifdef ULA_CTRL_ILLEGAL_TRAP_EN
  logic illegal_q, illegal_d;

  // Sticky flag: set by an accepted undefined op, cleared only by flush or reset
  always_comb begin
    illegal_d = illegal_q;
    if (bus.flush) begin
      illegal_d = 1'b0;
    end else if (accept_c && dec_undef) begin
      illegal_d = 1'b1;
    end
  end

  // Illegal flag register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      illegal_q <= 1'b0;
    end else begin
      illegal_q <= illegal_d;
    end
  end

  assign bus.illegal = illegal_q;
`else
  logic unused_dec_undef;
  assign unused_dec_undef = dec_undef;
  assign bus.illegal      = 1'b0;
`endif

  assign bus.issue_ready    = ready_c;
  assign bus.sinal_controle = sel_q;
  assign bus.ctrl_valid     = valid_q;
  assign bus.stall          = stall_q;
  assign bus.op_done        = done_q;
endmodule

// File: tb/tb_ula_controle_seq.sv
// Bench for ula_controle_seq: directed scenarios plus random traffic, checked
// against an op-level model (current select + cycles remaining).
module tb_ula_controle_seq;
  localparam int unsigned MUL_LAT = 4;
  localparam int unsigned DIV_LAT = 8;

  logic clock;
  logic reset_n;

  ula_controle_seq_if #(.OP_W(4), .FUNCT_W(4), .CTRL_W(4)) bus ();

  ula_controle_seq #(
    .OP_W   (4),
    .FUNCT_W(4),
    .CTRL_W (4),
    .MUL_LAT(MUL_LAT),
    .DIV_LAT(DIV_LAT)
  ) dut (
    .clock  (clock),
    .reset_n(reset_n),
    .bus    (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  // Model: code of the live op, cycles it still occupies (0 = nothing live), illegal flag
  int m_code = 15;
  int m_rem  = 0;
  int m_ill  = 0;

  int op_tab [0:11] = '{2, -1, 9, 10, 11, 12, 0, 1, 2, 3, 13, 14};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic void ref_decode(input int op, input int fn, output int code, output int undef);
    code  = 15;
    undef = 1;
    if (op <= 11 && op != 1) begin
      code  = op_tab[op];
      undef = 0;
    end else if (op == 1) begin
      if (fn <= 8) begin
        code  = fn;
        undef = 0;
      end else if (fn == 9) begin
        undef = 0;
      end
    end
  endfunction

  task automatic model_edge(input int v, input int op, input int fn, input int fl);
    int code;
    int undef;
    int ready;
    ready = (m_rem <= 1);
    if (fl != 0) begin
      m_rem = 0;
      m_ill = 0;
    end else if (v != 0 && ready != 0) begin
      ref_decode(op, fn, code, undef);
      m_code = code;
      if (code == 4 && MUL_LAT > 1)      m_rem = MUL_LAT;
      else if (code == 5 && DIV_LAT > 1) m_rem = DIV_LAT;
      else                               m_rem = 1;
`ifdef ULA_CTRL_ILLEGAL_TRAP_EN
      if (undef != 0) m_ill = 1;
`endif
    end else if (m_rem > 0) begin
      m_rem--;
    end
  endtask

  task automatic check_outs();
    chk("sel",     32'(bus.sinal_controle), 32'((m_rem > 0) ? m_code : 15));
    chk("valid",   32'(bus.ctrl_valid),     32'(m_rem > 0));
    chk("stall",   32'(bus.stall),          32'(m_rem > 1));
    chk("op_done", 32'(bus.op_done),        32'(m_rem == 1));
    chk("illegal", 32'(bus.illegal),        32'(m_ill));
  endtask

  // One clock: drive at negedge, check ready before the edge, check outputs after
  task automatic cycle(input int v, input int op, input int fn, input int fl);
    bus.issue_valid = v[0];
    bus.AluOP       = 4'(op);
    bus.funct       = 4'(fn);
    bus.flush       = fl[0];
    #1;
    chk("ready", 32'(bus.issue_ready), 32'(m_rem <= 1));
    @(posedge clock);
    model_edge(v, op, fn, fl);
    @(negedge clock);
    check_outs();
  endtask

  task automatic async_reset();
    reset_n = 1'b0;
    #1;
    m_rem = 0;
    m_ill = 0;
    check_outs();
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  initial begin
    int v, op, fn, fl;
    reset_n         = 1'b0;
    bus.issue_valid = 1'b0;
    bus.AluOP       = '0;
    bus.funct       = '0;
    bus.flush       = 1'b0;
    repeat (2) @(negedge clock);
    check_outs();
    reset_n = 1'b1;

    // addi: one-cycle op, then idle
    cycle(1, 8, 0, 0);
    chk("addi_sel", 32'(bus.sinal_controle), 32'd2);
    cycle(0, 0, 0, 0);
    chk("idle_sel", 32'(bus.sinal_controle), 32'd15);

    // mul held for MUL_LAT cycles
    cycle(1, 1, 4, 0);
    repeat (MUL_LAT + 1) cycle(0, 0, 0, 0);

    // div, then beq held by upstream until accepted with no bubble
    cycle(1, 1, 5, 0);
    repeat (DIV_LAT) cycle(1, 2, 0, 0);
    chk("beq_sel", 32'(bus.sinal_controle), 32'd9);
    cycle(0, 0, 0, 0);

    // flush on third div cycle beats a simultaneous andi
    cycle(1, 1, 5, 0);
    cycle(0, 0, 0, 0);
    cycle(0, 0, 0, 0);
    cycle(1, 6, 0, 1);
    chk("flush_sel", 32'(bus.sinal_controle), 32'd15);
    cycle(0, 0, 0, 0);

    // async reset mid-mul, then ori
    cycle(1, 1, 4, 0);
    cycle(0, 0, 0, 0);
    async_reset();
    cycle(1, 7, 0, 0);
    chk("ori_sel", 32'(bus.sinal_controle), 32'd1);

    // undefined AluOP, explicit jr, undefined funct, flush clearing
    cycle(1, 12, 0, 0);
    cycle(0, 0, 0, 0);
    cycle(1, 1, 9, 0);
    cycle(0, 0, 0, 1);
    cycle(1, 1, 9, 0);
    cycle(1, 1, 13, 0);
    cycle(0, 0, 0, 0);
    cycle(0, 0, 0, 1);

    // random traffic with occasional flush and reset
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        async_reset();
      end else begin
        v  = ($urandom_range(0, 9) < 7) ? 1 : 0;
        op = ($urandom_range(0, 2) == 0) ? 1 : int'($urandom_range(0, 15));
        fn = ($urandom_range(0, 1) == 0) ? int'($urandom_range(4, 5)) : int'($urandom_range(0, 15));
        fl = ($urandom_range(0, 24) == 0) ? 1 : 0;
        cycle(v, op, fn, fl);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
